trp_pulse_detector: RTL and testbench

Receive-side counterpart of the trapezoid pulse generator: it takes 12-bit ADC samples of the bipolar trapezoidal line signal centred on midscale and detects each pulse. For each pulse it reports the sign bit, the peak amplitude and the window integral. It sits between the ADC sampling front end and the bit/word deframer, and uses the same tick strobe `ce` (BR·NP ticks per second) as the transmit side.

---
 rtl/trp_pkg.sv | 15 +
 rtl/trp_peak_acc.sv | 43 ++++
 rtl/trp_pulse_detector.sv | 131 +++++++++++++
 tb/tb_trp_pulse_detector.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/trp_pkg.sv
// trp_pkg: line constants, tick-rate constants and FSM state encoding shared by the
// trapezoid pulse generator and detector.
package trp_pkg;
    localparam int TRP_NS0     = 2048;
    localparam int TRP_NP      = 20;
    localparam int TRP_NRF     = 4;
    localparam int TRP_BR      = 1000;
    localparam int TRP_TICK_HZ = TRP_BR * TRP_NP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/trp_peak_acc.sv
// trp_peak_acc: midscale-relative deviation, |dev|, signed window accumulator and peak register.
module trp_peak_acc
    import trp_pkg::*;
#(
    parameter int NS0 = TRP_NS0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        adc,
    input  logic               clr,
    input  logic               load,
    input  logic               en,
    output logic               dev_neg,
    output logic [11:0]        dev_abs,
    output logic signed [18:0] acc_nx,
    output logic [11:0]        peak_nx
);
    logic signed [12:0] dev;
    logic signed [18:0] acc_q;
    logic [11:0]        peak_q;

    // acc_nx/peak_nx already include the current sample so the FSM can publish them on the last tick
    always_comb begin
        dev     = $signed({1'b0, adc}) - $signed(13'(NS0));
        dev_neg = dev[12];
        dev_abs = dev_neg ? 12'(-dev) : dev[11:0];
        acc_nx  = load ? {{6{dev[12]}}, dev} : acc_q + {{6{dev[12]}}, dev};
        peak_nx = (load || dev_abs > peak_q) ? dev_abs : peak_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            peak_q <= '0;
        end else if (clr) begin
            acc_q  <= '0;
            peak_q <= '0;
        end else if (load || en) begin
            acc_q  <= acc_nx;
            peak_q <= peak_nx;
        end
    end
endmodule

// File: rtl/trp_pulse_detector.sv
// trp_pulse_detector: detects trapezoid pulses and reports sign, peak and window sum.
// Optional TRP_DET_STAT_EN adds n_pulse/n_err statistics counters.
module trp_pulse_detector
    import trp_pkg::*;
#(
    parameter int NS0   = TRP_NS0,
    parameter int TH    = 64,
    parameter int NP    = TRP_NP,
    parameter int QUIET = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic [11:0]        adc,
    output logic               S,
    output logic [11:0]        AMP,
    output logic signed [18:0] SUM,
    output logic               rdy,
    output logic               err,
    output logic               busy
`ifdef TRP_DET_STAT_EN
    ,
    output logic [15:0]        n_pulse,
    output logic [15:0]        n_err
`endif
);
    state_t             state_q;
    logic [5:0]         cnt_q;
    logic [3:0]         quiet_q;
    logic               s_cur_q, err_cur_q;
    logic               s_q, err_q, rdy_q, busy_q;
    logic [11:0]        amp_q;
    logic signed [18:0] sum_q;
    logic               dev_neg, over, opp;
    logic [11:0]        dev_abs, peak_nx;
    logic signed [18:0] acc_nx;
`ifdef TRP_DET_STAT_EN
    logic [15:0]        n_pulse_q, n_err_q;
`endif

    // s_cur_q=1 means positive, so equal to dev_neg means opposite sign
    assign over = dev_abs > 12'(TH);
    assign opp  = over && (dev_neg == s_cur_q);

    trp_peak_acc #(.NS0(NS0)) u_pa (
        .clk     (clk),
        .rst_n   (rst_n),
        .adc     (adc),
        .clr     (ce && state_q == HOLD),
        .load    (ce && state_q == IDLE && over),
        .en      (ce && state_q == ACQ),
        .dev_neg (dev_neg),
        .dev_abs (dev_abs),
        .acc_nx  (acc_nx),
        .peak_nx (peak_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quiet_q   <= '0;
            s_cur_q   <= 1'b0;
            err_cur_q <= 1'b0;
            s_q       <= 1'b0;
            amp_q     <= '0;
            sum_q     <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TRP_DET_STAT_EN
            n_pulse_q <= '0;
            n_err_q   <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (ce) begin
                case (state_q)
                    IDLE: if (over) begin
                        state_q   <= ACQ;
                        s_cur_q   <= ~dev_neg;
                        err_cur_q <= 1'b0;
                        cnt_q     <= 6'd1;
                        busy_q    <= 1'b1;
                    end
                    ACQ: begin
                        cnt_q     <= cnt_q + 6'd1;
                        err_cur_q <= err_cur_q | opp;
                        if (cnt_q == 6'(NP - 1)) begin
                            state_q <= HOLD;
                            quiet_q <= '0;
                            s_q     <= s_cur_q;
                            amp_q   <= peak_nx;
                            sum_q   <= acc_nx;
                            err_q   <= err_cur_q | opp;
                            rdy_q   <= 1'b1;
`ifdef TRP_DET_STAT_EN
                            n_pulse_q <= n_pulse_q + 16'd1;
                            n_err_q   <= n_err_q + {15'd0, err_cur_q | opp};
`endif
                        end
                    end
                    HOLD: begin
                        if (over) begin
                            quiet_q <= '0;
                        end else if (quiet_q == 4'(QUIET - 1)) begin
                            quiet_q <= '0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            quiet_q <= quiet_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign S    = s_q;
    assign AMP  = amp_q;
    assign SUM  = sum_q;
    assign err  = err_q;
    assign rdy  = rdy_q;
    assign busy = busy_q;
`ifdef TRP_DET_STAT_EN
    assign n_pulse = n_pulse_q;
    assign n_err   = n_err_q;
`endif
endmodule

// File: tb/tb_trp_pulse_detector.sv
// tb_trp_pulse_detector: directed pulses with a scoreboard of expected reports checked on rdy.
module tb_trp_pulse_detector;
    logic               clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
    logic [11:0]        adc = 12'd2048;
    logic               S, rdy, err, busy;
    logic [11:0]        AMP;
    logic signed [18:0] SUM;
`ifdef TRP_DET_STAT_EN
    logic [15:0]        n_pulse, n_err;
`endif

    always #5 clk = ~clk;

    trp_pulse_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .adc   (adc),
        .S     (S),
        .AMP   (AMP),
        .SUM   (SUM),
        .rdy   (rdy),
        .err   (err),
        .busy  (busy)
`ifdef TRP_DET_STAT_EN
        ,
        .n_pulse (n_pulse),
        .n_err   (n_err)
`endif
    );

    typedef struct {
        logic       s;
        logic [11:0] amp;
        int         sum;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, rdy_cnt = 0;
    logic rdy_prev = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int trap(input int i);
        return i < 4 ? 100 * (i + 1) : i < 16 ? 400 : 100 * (19 - i);
    endfunction

    // one ce tick with the given sample; r is rdy as seen after that tick's edge
    task automatic tick(input int v, input int gap, output logic r);
        adc = 12'(v);
        ce  = 1'b1;
        @(negedge clk);
        r  = rdy;
        ce = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic quiet(input int n);
        logic r;
        for (int i = 0; i < n; i++) tick(2048, 10, r);
    endtask

    task automatic trap_pulse(input int sgn);
        logic r;
        for (int i = 0; i < 20; i++) begin
            tick(2048 + sgn * trap(i), 10, r);
            if (i == 18) chk("rdy_before_np", r, 0);
            if (i == 19) chk("rdy_at_np", r, 1);
        end
        quiet(6);
    endtask

    always @(negedge clk) begin
        if (rdy) begin
            rdy_cnt++;
            chk("rdy_single", rdy_prev, 0);
            chk("rdy_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("S", S, e.s);
                chk("AMP", AMP, e.amp);
                chk("SUM", $signed(SUM), e.sum);
                chk("err", err, e.e);
            end
        end
        rdy_prev = rdy;
    end

    initial begin
        int   sum, base;
        logic r, seen_busy;
`ifdef TRP_DET_STAT_EN
        logic [15:0] np0, ne0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_S", S, 0);
        chk("rst_AMP", AMP, 0);
        chk("rst_SUM", $signed(SUM), 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sum = 0;
        for (int i = 0; i < 20; i++) sum += trap(i);
        base = rdy_cnt;
        sb.push_back('{1'b1, 12'd400, sum, 1'b0});
        trap_pulse(1);
        chk("pos_rdy_count", rdy_cnt - base, 1);
        chk("pos_busy_after", busy, 0);

        base = rdy_cnt;
        sb.push_back('{1'b0, 12'd400, -sum, 1'b0});
        trap_pulse(-1);
        chk("neg_rdy_count", rdy_cnt - base, 1);

        base = rdy_cnt;
        seen_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick((i % 2) ? 2112 : 1984, 1, r);
            seen_busy |= busy;
        end
        chk("alt_no_rdy", rdy_cnt - base, 0);
        chk("alt_busy", seen_busy, 0);
        quiet(2);

        base = rdy_cnt;
        sb.push_back('{1'b1, 12'd300, 0, 1'b1});
        for (int i = 0; i < 20; i++) tick(i < 6 ? 2348 : i < 12 ? 1748 : 2048, 10, r);
        quiet(6);
        chk("bip_rdy_count", rdy_cnt - base, 1);

        base = rdy_cnt;
        for (int i = 0; i < 10; i++) tick(2048 + trap(i), 10, r);
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_S", S, 0);
        chk("abort_AMP", AMP, 0);
        chk("abort_SUM", $signed(SUM), 0);
        chk("abort_err", err, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rdy", rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(3);
        chk("abort_no_rdy", rdy_cnt - base, 0);
        sb.push_back('{1'b1, 12'd400, sum, 1'b0});
        trap_pulse(1);
        chk("post_abort_rdy_count", rdy_cnt - base, 1);

        base = rdy_cnt;
`ifdef TRP_DET_STAT_EN
        np0 = n_pulse;
        ne0 = n_err;
`endif
        sb.push_back('{1'b1, 12'd400, 8000, 1'b0});
        for (int i = 0; i < 40; i++) tick(2448, 10, r);
        chk("held_busy_in_hold", busy, 1);
        quiet(3);
        chk("held_busy_q3", busy, 1);
        quiet(1);
        chk("held_busy_q4", busy, 0);
        quiet(10);
        chk("held_rdy_count", rdy_cnt - base, 1);
`ifdef TRP_DET_STAT_EN
        chk("n_pulse", n_pulse - np0, 1);
        chk("n_err", n_err - ne0, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
